parallel_slave_regs: RTL and testbench

- Parametrised, clocked successor to the CPLD parallel-bus slave.
- Maps a window of NREG read/write registers onto the external async bus (ADR, Data, BWR, BRD).
- Bus strobes are synchronised into CLK; a small FSM qualifies write and read cycles and flags protocol errors.
- Register contents are exported to the rest of the CPLD as a flat bus plus a one-cycle write-strobe.

---
 rtl/parallel_slave_regs.sv | 175 +++++++++++++++++
 tb/tb_parallel_slave_regs.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/parallel_slave_regs.sv
// rtl/parallel_slave_regs.sv - clocked parallel-bus slave register window
//
// Maps NREG read/write registers onto an asynchronous parallel bus.
// Bus strobes are synchronised into clk. A small FSM qualifies write and
// read cycles and flags protocol errors. Register contents are exported
// as a flat bus, together with a one-cycle write strobe.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous reset, active-high
//   adr      - bus address (ADR_W)
//   data     - bidirectional bus data (DATA_W)
//   bwr      - write strobe, active-low; the write commits on its rising edge
//   brd      - read strobe, active-low
//   regs     - register contents; register k is at [k*DATA_W +: DATA_W]
//   wr_pulse - one-clk pulse for each committed register write
//   wr_idx   - offset of the last committed write
//   err      - sticky protocol-error flag
//
// Optional build macro:
//   STATUS_REG_EN - offset NREG becomes a status register. A read returns
//                   {err, commit count}. A write clears err and the count.

module parallel_slave_regs #(
  parameter int                ADR_W    = 10,
  parameter int                DATA_W   = 8,
  parameter int                OFS_W    = 4,
  parameter logic [ADR_W-1:0]  BASE_ADR = 10'h050,
  parameter int                NREG     = 4,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADR_W-1:0]       adr,
  inout  wire  [DATA_W-1:0]      data,
  input  logic                   bwr,
  input  logic                   brd,
  output logic [NREG*DATA_W-1:0] regs,
  output logic                   wr_pulse,
  output logic [OFS_W-1:0]       wr_idx,
  output logic                   err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  // NREG is widened by one bit so that the comparison is exact even when
  // NREG == 2^OFS_W.
  localparam logic [OFS_W:0] NREG_L = (OFS_W+1)'(NREG);

  function automatic logic win_hit(input logic [ADR_W-1:0] a);
    return a[ADR_W-1:OFS_W] == BASE_ADR[ADR_W-1:OFS_W];
  endfunction

  logic [1:0]             bwr_s, brd_s;
  logic [ADR_W-1:0]       adr_p1, adr_p2;
  logic [DATA_W-1:0]      dat_p1, dat_p2;
  logic                   bwr_sync, brd_sync;

  logic [1:0]             state;
  logic                   wr_abort;
  logic [NREG*DATA_W-1:0] regs_q;
  logic [DATA_W-1:0]      rd_val, rd_latch;
  logic [OFS_W-1:0]       wr_ofs, rd_ofs;
  logic                   wr_hit;

`ifdef STATUS_REG_EN
  logic [DATA_W-2:0]      wr_cnt;
`endif

  assign bwr_sync = bwr_s[1];
  assign brd_sync = brd_s[1];
  assign wr_ofs   = adr_p2[OFS_W-1:0];
  assign wr_hit   = win_hit(adr_p2);
  assign rd_ofs   = adr[OFS_W-1:0];

  // The strobes go through two flops. The address and data go through an
  // identical pipeline, so that the values seen at commit time line up with
  // the synchronised strobe edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bwr_s  <= 2'b11;
      brd_s  <= 2'b11;
      adr_p1 <= '0;
      adr_p2 <= '0;
      dat_p1 <= '0;
      dat_p2 <= '0;
    end else begin
      bwr_s  <= {bwr_s[0], bwr};
      brd_s  <= {brd_s[0], brd};
      adr_p1 <= adr;
      adr_p2 <= adr_p1;
      dat_p1 <= data;
      dat_p2 <= dat_p1;
    end
  end

  // Read mux on the raw address. Unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NREG; k++) begin
      if (rd_ofs == OFS_W'(k)) rd_val = regs_q[k*DATA_W +: DATA_W];
    end
`ifdef STATUS_REG_EN
    if ({1'b0, rd_ofs} == NREG_L) rd_val = {err, wr_cnt};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_abort <= 1'b0;
      regs_q   <= {NREG{RST_VAL}};
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
      err      <= 1'b0;
`ifdef STATUS_REG_EN
      wr_cnt   <= '0;
`endif
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          wr_abort <= 1'b0;
          if (!bwr_sync && !brd_sync) err <= 1'b1;
          else if (!bwr_sync)         state <= ST_WR;
          else if (!brd_sync)         state <= ST_RD;
        end
        ST_WR: begin
          if (!brd_sync) begin
            // A read strobe overlaps the write. Poison this cycle and leave
            // only after both strobes have returned high.
            err      <= 1'b1;
            wr_abort <= 1'b1;
          end else if (bwr_sync) begin
            state <= ST_IDLE;
            if (!wr_abort && wr_hit) begin
              if ({1'b0, wr_ofs} < NREG_L) begin
                for (int k = 0; k < NREG; k++) begin
                  if (wr_ofs == OFS_W'(k)) regs_q[k*DATA_W +: DATA_W] <= dat_p2;
                end
                wr_pulse <= 1'b1;
                wr_idx   <= wr_ofs;
`ifdef STATUS_REG_EN
                wr_cnt   <= wr_cnt + 1'b1;
              end else if ({1'b0, wr_ofs} == NREG_L) begin
                err      <= 1'b0;
                wr_cnt   <= '0;
`endif
              end
            end
          end
        end
        ST_RD: begin
          if (!bwr_sync) err <= 1'b1;
          if (brd_sync)  state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The output latch tracks the addressed register until the read cycle is
  // qualified. It then holds that value, so data stays stable for the whole
  // read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rd_latch <= '0;
    else if (state != ST_RD) rd_latch <= rd_val;
  end

  assign data = (!brd && win_hit(adr)) ? rd_latch : {DATA_W{1'bz}};
  assign regs = regs_q;

endmodule

// File: tb/tb_parallel_slave_regs.sv
// tb/tb_parallel_slave_regs.sv - directed bench for parallel_slave_regs

module tb_parallel_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  adr = '0;
  logic        bwr = 1'b1;
  logic        brd = 1'b1;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dat = '0;
  tri1  [7:0]  data;
  logic [31:0] regs;
  logic        wr_pulse;
  logic [3:0]  wr_idx;
  logic        err;

  int n_tests   = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;
  int base;
  logic [7:0] rd;

  assign data = tb_oe ? tb_dat : 8'hzz;

  parallel_slave_regs dut (
    .clk      (clk),
    .rst      (rst),
    .adr      (adr),
    .data     (data),
    .bwr      (bwr),
    .brd      (brd),
    .regs     (regs),
    .wr_pulse (wr_pulse),
    .wr_idx   (wr_idx),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk); adr = a; tb_dat = d; tb_oe = 1'b1; bwr = 1'b0;
    repeat (4) @(negedge clk); bwr = 1'b1;
    repeat (4) @(negedge clk); tb_oe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk); adr = a; brd = 1'b0;
    repeat (4) @(negedge clk); d = data; brd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_regs", regs, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_pulse", {31'b0, wr_pulse}, 32'h0);
    check("rst_idx", {28'b0, wr_idx}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      bus_read(10'h050 + 10'(i), rd);
      check($sformatf("rst_read_%0d", i), {24'b0, rd}, 32'h0);
    end

    // Write 0xA5 to offset 2. The register updates on the third clock edge
    // after the rising edge of bwr.
    @(negedge clk); adr = 10'h052; tb_dat = 8'hA5; tb_oe = 1'b1; bwr = 1'b0;
    repeat (4) @(negedge clk); bwr = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_pre_pulse", {31'b0, wr_pulse}, 32'h0);
    check("lat_pre_reg", {24'b0, regs[23:16]}, 32'h0);
    @(negedge clk);
    check("lat_pulse", {31'b0, wr_pulse}, 32'h1);
    check("lat_reg", {24'b0, regs[23:16]}, 32'hA5);
    check("lat_idx", {28'b0, wr_idx}, 32'h2);
    repeat (2) @(negedge clk); tb_oe = 1'b0;
    repeat (2) @(negedge clk);
    check("one_pulse", pulse_cnt, 1);
    bus_read(10'h052, rd);
    check("read_a5", {24'b0, rd}, 32'hA5);

    // Writes that miss the window, or that target an offset >= NREG, are dropped.
    bus_write(10'h060, 8'h3C);
    bus_write(10'h055, 8'h3C);
    check("drop_pulse", pulse_cnt, 1);
    check("drop_regs", regs, 32'h00A50000);
    bus_read(10'h060, rd);
    check("miss_hiz", {24'b0, rd}, 32'hFF);

    // Back-to-back writes to the boundary offsets 0 and NREG-1.
    bus_write(10'h050, 8'h5A);
    bus_write(10'h053, 8'h81);
    check("b2b_regs", regs, 32'h81A5005A);
    check("b2b_idx", {28'b0, wr_idx}, 32'h3);
    check("b2b_pulse", pulse_cnt, 3);

    // Both strobes low for 4 clocks: protocol error, with no commit.
    @(negedge clk); adr = 10'h051; bwr = 1'b0; brd = 1'b0;
    repeat (4) @(negedge clk); bwr = 1'b1; brd = 1'b1;
    repeat (6) @(negedge clk);
    check("err_set", {31'b0, err}, 32'h1);
    check("err_regs", regs, 32'h81A5005A);
    check("err_pulse", pulse_cnt, 3);
    repeat (10) @(negedge clk);
    check("err_sticky", {31'b0, err}, 32'h1);

`ifdef STATUS_REG_EN
    bus_read(10'h054, rd);
    check("status_err", {24'b0, rd}, 32'h83);
    bus_write(10'h054, 8'h00);
    check("status_clr_err", {31'b0, err}, 32'h0);
    check("status_clr_pulse", pulse_cnt, 3);
    bus_read(10'h054, rd);
    check("status_clr_read", {24'b0, rd}, 32'h00);
`else
    bus_read(10'h054, rd);
    check("ofs4_read", {24'b0, rd}, 32'h00);
    bus_write(10'h054, 8'hFF);
    check("ofs4_err", {31'b0, err}, 32'h1);
    check("ofs4_pulse", pulse_cnt, 3);
`endif

    // Reset pulse in the middle of a write cycle.
    @(negedge clk); adr = 10'h051; tb_dat = 8'h77; tb_oe = 1'b1; bwr = 1'b0;
    repeat (4) @(negedge clk);
    base = pulse_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_regs_now", regs, 32'h0);
    bwr = 1'b1; rst = 1'b0;
    repeat (10) @(negedge clk); tb_oe = 1'b0;
    check("midrst_regs", regs, 32'h0);
    check("midrst_err", {31'b0, err}, 32'h0);
    check("midrst_pulse", pulse_cnt, base);

`ifdef STATUS_REG_EN
    for (int i = 0; i < 130; i++) bus_write(10'h050, 8'(i));
    bus_read(10'h054, rd);
    check("status_wrap", {24'b0, rd}, 32'h02);
    check("wrap_reg0", {24'b0, regs[7:0]}, 32'd129);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
